fetch_prefetch_unit: RTL and testbench

Parametrised instruction fetch front end for the pipelined RISC-V core. It replaces the combinational-memory fetch path with a valid/ready request channel and an in-order, variable-latency response channel. Fetched words are buffered in a prefetch FIFO and delivered to decode through a valid/ready handshake. Execute-stage redirects (taken branch or jump) flush the FIFO and discard any responses still in flight.

---
 rtl/fetch_prefetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order responses
// into a prefetch FIFO, and redirect flush that drops stale in-flight responses.
module fetch_prefetch_unit #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_ADDR_WIDTH      = 11,
  parameter int P_FIFO_DEPTH      = 4,
  parameter int P_MAX_OUTSTANDING = 2,
  parameter int P_RESET_PC        = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  output logic                              o_imem_req_valid,
  input  logic                              i_imem_req_ready,
  output logic [P_ADDR_WIDTH-1:0]           o_imem_req_addr,
  input  logic                              i_imem_rsp_valid,
  input  logic [P_DATA_WIDTH-1:0]           i_imem_rsp_data,
  input  logic                              i_redirect,
  input  logic [P_ADDR_WIDTH-1:0]           i_redirect_pc,
  output logic                              o_instr_valid,
  input  logic                              i_instr_ready,
  output logic [P_DATA_WIDTH-1:0]           o_instr,
  output logic [P_ADDR_WIDTH-1:0]           o_pc,
  output logic [P_ADDR_WIDTH-1:0]           o_pc4,
  output logic [$clog2(P_FIFO_DEPTH):0]     o_fifo_count
);

  localparam int L_PTR_W = $clog2(P_FIFO_DEPTH);
  localparam int L_CNT_W = L_PTR_W + 1;
  localparam int L_OUT_W = $clog2(P_MAX_OUTSTANDING + 1);
  localparam logic [31:0] L_DEPTH = P_FIFO_DEPTH;
  localparam logic [31:0] L_MAX_OUT = P_MAX_OUTSTANDING;
  localparam logic [P_ADDR_WIDTH-1:0] L_RESET_PC = P_RESET_PC[P_ADDR_WIDTH-1:0];
  localparam logic [P_ADDR_WIDTH-1:0] L_PC_STEP = P_ADDR_WIDTH'(4);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [P_ADDR_WIDTH-1:0]   r_req_pc;
  logic [P_ADDR_WIDTH-1:0]   r_head_pc;
  logic [L_PTR_W-1:0]        r_rd_ptr;
  logic [L_PTR_W-1:0]        r_wr_ptr;
  logic [L_CNT_W-1:0]        r_count;
  logic [L_OUT_W-1:0]        r_out_total;
  logic [L_OUT_W-1:0]        r_drop_cnt;
  logic [P_DATA_WIDTH-1:0]   r_mem [P_FIFO_DEPTH];

  logic [L_OUT_W-1:0]        w_live;
  logic                      w_credit_ok;
  logic                      w_out_ok;
  logic                      w_req_valid;
  logic                      w_accept;
  logic                      w_rsp;
  logic                      w_drop;
  logic                      w_push;
  logic                      w_instr_valid;
  logic                      w_pop;
  logic [L_OUT_W-1:0]        w_redir_drop;
  logic [P_ADDR_WIDTH-1:0]   w_redir_pc;
  logic                      w_unused_pc_lsb;

  // Credits count live in-flight requests so every live response has a free slot.
  assign w_live        = r_out_total - r_drop_cnt;
  assign w_credit_ok   = (32'(r_count) + 32'(w_live)) < L_DEPTH;
  assign w_out_ok      = 32'(r_out_total) < L_MAX_OUT;
  assign w_req_valid   = i_rst_n && !i_redirect && w_out_ok && w_credit_ok;
  assign w_accept      = w_req_valid && i_imem_req_ready;
  assign w_rsp         = i_imem_rsp_valid && (r_out_total != '0);
  assign w_drop        = w_rsp && (r_drop_cnt != '0);
  assign w_push        = w_rsp && !w_drop;
  assign w_instr_valid = (r_count != '0);
  assign w_pop         = w_instr_valid && i_instr_ready;
  assign w_redir_drop  = r_out_total - L_OUT_W'(w_rsp);
  assign w_redir_pc    = {i_redirect_pc[P_ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_req_pc;
  assign o_instr_valid    = w_instr_valid;
  assign o_instr          = w_instr_valid ? r_mem[r_rd_ptr] : '0;
  assign o_pc             = r_head_pc;
  assign o_pc4            = r_head_pc + L_PC_STEP;
  assign o_fifo_count     = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (i_redirect && (w_redir_drop != '0)) w_state_nxt = S_DRAIN;
        else                                    w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (i_redirect)                                          w_state_nxt = (w_redir_drop != '0) ? S_DRAIN : S_RUN;
        else if (w_drop && (r_drop_cnt == L_OUT_W'(1)))          w_state_nxt = S_RUN;
        else                                                     w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Redirect outranks issue, push and pop; the same-cycle response is counted stale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_pc    <= L_RESET_PC;
      r_head_pc   <= L_RESET_PC;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_total <= '0;
      r_drop_cnt  <= '0;
    end else if (i_redirect) begin
      r_req_pc    <= w_redir_pc;
      r_head_pc   <= w_redir_pc;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_total <= w_redir_drop;
      r_drop_cnt  <= w_redir_drop;
    end else begin
      if (w_accept) r_req_pc <= r_req_pc + L_PC_STEP;
      if (w_drop)   r_drop_cnt <= r_drop_cnt - L_OUT_W'(1);
      if (w_push)   r_wr_ptr <= r_wr_ptr + L_PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + L_PTR_W'(1);
        r_head_pc <= r_head_pc + L_PC_STEP;
      end
      r_out_total <= r_out_total + L_OUT_W'(w_accept) - L_OUT_W'(w_rsp);
      r_count     <= r_count + L_CNT_W'(w_push) - L_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_redirect) r_mem[r_wr_ptr] <= i_imem_rsp_data;
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a queue-based in-order memory model
// whose responses can be paused to hold requests in flight.
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [10:0] pc;
  logic [10:0] pc4;
  logic [2:0]  fifo_count;
  logic        mem_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] mem_q[$];

  fetch_prefetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr          (instr),
    .o_pc             (pc),
    .o_pc4            (pc4),
    .o_fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [10:0] a);
    return 32'hC0DE_0000 | {21'h0, a};
  endfunction

  // Memory: answers accepted requests in order, one per cycle, when mem_en is set.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
    end else begin
      if (req_valid && req_ready) mem_q.push_back(req_addr);
      if (mem_en && mem_q.size() > 0) begin
        rsp_valid <= 1'b1;
        rsp_data  <= dat(mem_q.pop_front());
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"},   32'(req_valid),   32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"},       instr,            32'h0);
    chk({tag, "_pc"},          32'(pc),          32'h000);
    chk({tag, "_pc4"},         32'(pc4),         32'h004);
    chk({tag, "_count"},       32'(fifo_count),  32'h0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_ready = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 11'h0; mem_en = 1'b1;
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", 32'(req_valid), 32'h1);
    chk("first_req_addr",  32'(req_addr),  32'h000);
    tick();
    chk("second_req_addr", 32'(req_addr),    32'h004);
    chk("no_instr_yet",    32'(instr_valid), 32'h0);

    // Streaming: one instruction per cycle from cycle 2
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stream_valid", 32'(instr_valid), 32'h1);
      chk("stream_pc",    32'(pc),          32'(4 * k));
      chk("stream_instr", instr,            dat(11'(4 * k)));
    end
    chk("stream_count", 32'(fifo_count), 32'h1);

    // Decode stall: FIFO fills, credits run out
    instr_ready = 1'b0;
    repeat (10) tick();
    chk("stall_count",     32'(fifo_count), 32'h4);
    chk("stall_req_valid", 32'(req_valid),  32'h0);
    chk("stall_head_pc",   32'(pc),         32'h014);
    instr_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("resume_valid", 32'(instr_valid), 32'h1);
      chk("resume_pc",    32'(pc),          32'(20 + 4 * k));
      chk("resume_instr", instr,            dat(11'(20 + 4 * k)));
    end

    // Redirect to 0x010 with memory paused so two requests stay in flight
    redirect = 1'b1; redirect_pc = 11'h010; mem_en = 1'b0;
    #1;
    chk("redir_blocks_req", 32'(req_valid), 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir1_instr_valid", 32'(instr_valid), 32'h0);
    chk("redir1_count",       32'(fifo_count),  32'h0);
    chk("redir1_req_addr",    32'(req_addr),    32'h010);
    tick();
    chk("redir1_req_addr2", 32'(req_addr),  32'h014);
    chk("redir1_req_valid", 32'(req_valid), 32'h1);
    tick();
    chk("max_outstanding", 32'(req_valid), 32'h0);
    redirect = 1'b1; redirect_pc = 11'h102;
    tick();
    redirect = 1'b0; mem_en = 1'b1;
    #1;
    chk("drain_req_valid",   32'(req_valid),   32'h0);
    chk("drain_pc",          32'(pc),          32'h100);
    chk("drain_instr_valid", 32'(instr_valid), 32'h0);
    tick();
    chk("drain_req_valid2", 32'(req_valid), 32'h0);
    tick();
    chk("drain_done_req_valid", 32'(req_valid),   32'h1);
    chk("drain_done_req_addr",  32'(req_addr),    32'h100);
    chk("drain_done_no_instr",  32'(instr_valid), 32'h0);
    tick();
    chk("drop_not_pushed", 32'(instr_valid), 32'h0);
    tick();
    chk("new_path_valid", 32'(instr_valid), 32'h1);
    chk("new_path_pc",    32'(pc),          32'h100);
    chk("new_path_pc4",   32'(pc4),         32'h104);
    chk("new_path_instr", instr,            dat(11'h100));
    tick();
    chk("new_path_pc_next", 32'(pc), 32'h104);

    // Redirect together with a response and a pop, two outstanding
    mem_en = 1'b0; instr_ready = 1'b0;
    tick();
    chk("pre_count",     32'(fifo_count), 32'h2);
    chk("pre_req_addr",  32'(req_addr),   32'h110);
    mem_en = 1'b1; instr_ready = 1'b1;
    tick();
    chk("pre2_count",     32'(fifo_count), 32'h1);
    chk("pre2_pc",        32'(pc),         32'h108);
    chk("pre2_req_valid", 32'(req_valid),  32'h0);
    redirect = 1'b1; redirect_pc = 11'h200;
    tick();
    redirect = 1'b0;
    #1;
    chk("combo_count",       32'(fifo_count),  32'h0);
    chk("combo_instr_valid", 32'(instr_valid), 32'h0);
    chk("combo_req_addr",    32'(req_addr),    32'h200);
    chk("combo_req_valid",   32'(req_valid),   32'h1);
    tick();
    chk("combo_stale_dropped", 32'(instr_valid), 32'h0);
    tick();
    chk("combo_pc",    32'(pc), 32'h200);
    chk("combo_instr", instr,   dat(11'h200));

    // Address wrap, redirect target with low bits set
    redirect = 1'b1; redirect_pc = 11'h7FA;
    tick();
    redirect = 1'b0;
    #1;
    chk("wrap_req_addr0", 32'(req_addr), 32'h7F8);
    tick();
    chk("wrap_req_addr1", 32'(req_addr), 32'h7FC);
    tick();
    chk("wrap_req_addr2", 32'(req_addr), 32'h000);
    chk("wrap_pc0",       32'(pc),       32'h7F8);
    chk("wrap_pc4_0",     32'(pc4),      32'h7FC);
    tick();
    chk("wrap_pc1",    32'(pc),  32'h7FC);
    chk("wrap_pc4_1",  32'(pc4), 32'h000);
    chk("wrap_instr1", instr,    dat(11'h7FC));
    tick();
    chk("wrap_pc2",    32'(pc),  32'h000);
    chk("wrap_pc4_2",  32'(pc4), 32'h004);
    chk("wrap_instr2", instr,    dat(11'h000));

    // Memory not ready: request held stable
    req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_req_valid", 32'(req_valid), 32'h1);
      chk("hold_req_addr",  32'(req_addr),  32'h008);
    end
    req_ready = 1'b1;
    tick();
    chk("hold_release_empty", 32'(instr_valid), 32'h0);
    tick();
    chk("hold_release_pc",    32'(pc), 32'h008);
    chk("hold_release_instr", instr,   dat(11'h008));

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_req_valid", 32'(req_valid), 32'h1);
    chk("restart_req_addr",  32'(req_addr),  32'h000);
    tick();
    chk("restart_req_addr2", 32'(req_addr), 32'h004);
    tick();
    chk("restart_valid", 32'(instr_valid), 32'h1);
    chk("restart_pc",    32'(pc),          32'h000);
    chk("restart_instr", instr,            dat(11'h000));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
